// File: rtl/alu_secuencial_pkg.sv
// Shared types and the single-cycle ALU function for the sequential ALU.
// The function works on a 64-bit container and masks the result to the live width n (4..64).
package alu_secuencial_pkg;

  typedef enum logic [4:0] {
    OP_AND   = 5'd0,  OP_OR    = 5'd1,  OP_XOR   = 5'd2,  OP_NOT   = 5'd3,
    OP_LSR_A = 5'd4,  OP_LSL_A = 5'd5,  OP_LSR_B = 5'd6,  OP_LSL_B = 5'd7,
    OP_ADD   = 5'd8,  OP_SUB   = 5'd9,  OP_ASR_A = 5'd10, OP_ASL_A = 5'd11,
    OP_ASR_B = 5'd12, OP_ASL_B = 5'd13, OP_ROR   = 5'd14, OP_CERO  = 5'd15,
    OP_MUL   = 5'd16, OP_DIV   = 5'd17, OP_MOD   = 5'd18
  } op_alu_t;

  typedef enum logic [1:0] {LIBRE, CALCULO, RESULTADO} estado_alu_t;

  typedef enum logic [1:0] {MODO_MUL, MODO_DIV, MODO_MOD} modo_iter_t;

  typedef struct packed {
    logic [63:0] res;
    logic        carry;
    logic        ovf;
  } legado_t;

  function automatic logic es_iterativo(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

  function automatic legado_t alu_legado(input logic [4:0] op, input logic [63:0] a,
                                         input logic [63:0] b, input logic [6:0] n);
    legado_t     r;
    logic [63:0] mascara;
    logic [64:0] suma;
    logic [63:0] dif;
    logic [5:0]  msb;
    logic [5:0]  giro;
    msb     = 6'(n - 7'd1);
    mascara = (64'd1 << n) - 64'd1;
    suma    = {1'b0, a} + {1'b0, b};
    dif     = a - b;
    giro    = b[5:0] & msb;
    r       = '0;
    case (op)
      OP_AND:   r.res = a & b;
      OP_OR:    r.res = a | b;
      OP_XOR:   r.res = a ^ b;
      OP_NOT:   r.res = ~a;
      OP_LSR_A: r.res = a >> 1;
      OP_LSL_A: r.res = a << 1;
      OP_LSR_B: r.res = b >> 1;
      OP_LSL_B: r.res = b << 1;
      OP_ADD: begin
        r.res   = suma[63:0];
        r.carry = suma[n];
        r.ovf   = (a[msb] == b[msb]) && (suma[msb] != a[msb]);
      end
      OP_SUB: begin
        r.res   = dif;
        r.carry = (a >= b);
        r.ovf   = (a[msb] != b[msb]) && (dif[msb] != a[msb]);
      end
      OP_ASR_A: r.res = (a >> 1) | ({63'd0, a[msb]} << msb);
      OP_ASL_A: r.res = a << 1;
      OP_ASR_B: r.res = (b >> 1) | ({63'd0, b[msb]} << msb);
      OP_ASL_B: r.res = b << 1;
      // a shift by the full width yields 0, so a zero rotate needs no special case
      OP_ROR:   r.res = (a >> giro) | (a << (n - {1'b0, giro}));
      default:  r.res = '0;
    endcase
    r.res = r.res & mascara;
    return r;
  endfunction

endpackage

// File: rtl/multiplicador_divisor_iterativo.sv
// Iterative unsigned shift-add multiplier and restoring divider over a 2N-bit working register.
// The first iteration is applied on the start edge; hecho is high once all N are done.
module multiplicador_divisor_iterativo
  import alu_secuencial_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inicio,
  input  logic [1:0]   modo,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         hecho,
  output logic [N-1:0] resultado,
  output logic         alto_no_cero,
  output logic         div_cero
);
  localparam int unsigned CW = $clog2(N);

  logic [2*N-1:0] trabajo_q, trabajo_d, fuente, paso;
  logic [N-1:0]   divisor_q, divisor_d, b_oper;
  logic [1:0]     modo_q, modo_d, modo_oper;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ocupado_q, ocupado_d, div_cero_q, div_cero_d;
  logic [N:0]     suma_mul, resto_desp, resto_rest;

  always_comb begin
    fuente     = inicio ? {{N{1'b0}}, a} : trabajo_q;
    b_oper     = inicio ? b : divisor_q;
    modo_oper  = inicio ? modo : modo_q;
    suma_mul   = {1'b0, fuente[2*N-1:N]} + {1'b0, b_oper};
    resto_desp = {fuente[2*N-1:N], fuente[N-1]};
    resto_rest = resto_desp - {1'b0, b_oper};
    // divide by zero falls out naturally: every quotient bit sets and the remainder ends as A
    if (modo_oper == MODO_MUL)
      paso = fuente[0] ? {suma_mul, fuente[N-1:1]} : {1'b0, fuente[2*N-1:N], fuente[N-1:1]};
    else if (resto_desp >= {1'b0, b_oper})
      paso = {resto_rest[N-1:0], fuente[N-2:0], 1'b1};
    else
      paso = {resto_desp[N-1:0], fuente[N-2:0], 1'b0};

    trabajo_d  = trabajo_q;
    divisor_d  = divisor_q;
    modo_d     = modo_q;
    cnt_d      = cnt_q;
    ocupado_d  = ocupado_q;
    div_cero_d = div_cero_q;
    if (inicio) begin
      trabajo_d  = paso;
      divisor_d  = b;
      modo_d     = modo;
      cnt_d      = CW'(N - 1);
      ocupado_d  = 1'b1;
      div_cero_d = (modo != MODO_MUL) && (b == '0);
    end else if (ocupado_q) begin
      if (cnt_q != '0) begin
        trabajo_d = paso;
        cnt_d     = cnt_q - 1'b1;
      end else begin
        ocupado_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trabajo_q  <= '0;
      divisor_q  <= '0;
      modo_q     <= MODO_MUL;
      cnt_q      <= '0;
      ocupado_q  <= 1'b0;
      div_cero_q <= 1'b0;
    end else begin
      trabajo_q  <= trabajo_d;
      divisor_q  <= divisor_d;
      modo_q     <= modo_d;
      cnt_q      <= cnt_d;
      ocupado_q  <= ocupado_d;
      div_cero_q <= div_cero_d;
    end
  end

  assign hecho        = ocupado_q && (cnt_q == '0);
  assign resultado    = (modo_q == MODO_MOD) ? trabajo_q[2*N-1:N] : trabajo_q[N-1:0];
  assign alto_no_cero = (modo_q == MODO_MUL) && (|trabajo_q[2*N-1:N]);
  assign div_cero     = div_cero_q;

endmodule

// File: rtl/unidad_logico_aritmetica_secuencial.sv
// Registered ALU with valid/ready handshake: single-cycle logic/shift/add plus iterative MUL/DIV/MOD.
//   estado    | meaning
//   LIBRE     | idle, ready for an operation
//   CALCULO   | multiplier/divider iterating, producer stalled
//   RESULTADO | result and flags held until the consumer takes them
module unidad_logico_aritmetica_secuencial
  import alu_secuencial_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         entrada_valida,
  output logic         entrada_lista,
  input  logic [N-1:0] operador1,
  input  logic [N-1:0] operador2,
  input  logic [4:0]   ALUControl,
  output logic         salida_valida,
  input  logic         salida_lista,
  output logic [N-1:0] resultadoFinal,
  output logic         flagNegativo,
  output logic         flagCero,
  output logic         flagOverflow,
  output logic         flagCarry,
  output logic         flagDivCero
);
  estado_alu_t  estado_q, estado_d;
  logic [N-1:0] resultado_q, resultado_d;
  logic         neg_q, neg_d, cero_q, cero_d, ovf_q, ovf_d;
  logic         carry_q, carry_d, divcero_q, divcero_d, valida_q, valida_d;
  logic         acepta, iter_op, inicio, nueva, hecho, alto_no_cero, div_cero;
  logic [N-1:0] res_iter;
  logic [1:0]   modo;
  legado_t      legado;

  assign entrada_lista = (estado_q == LIBRE) || ((estado_q == RESULTADO) && salida_lista);
  assign acepta        = entrada_valida && entrada_lista;
  assign iter_op       = es_iterativo(ALUControl);
  assign inicio        = acepta && iter_op;
  assign modo          = (ALUControl == OP_DIV) ? MODO_DIV :
                         (ALUControl == OP_MOD) ? MODO_MOD : MODO_MUL;
  assign legado        = alu_legado(ALUControl, 64'(operador1), 64'(operador2), 7'(N));

  multiplicador_divisor_iterativo #(.N(N)) u_iter (
    .clk          (clk),
    .rst_n        (rst_n),
    .inicio       (inicio),
    .modo         (modo),
    .a            (operador1),
    .b            (operador2),
    .hecho        (hecho),
    .resultado    (res_iter),
    .alto_no_cero (alto_no_cero),
    .div_cero     (div_cero)
  );

  always_comb begin
    estado_d    = estado_q;
    resultado_d = resultado_q;
    neg_d       = neg_q;
    cero_d      = cero_q;
    ovf_d       = ovf_q;
    carry_d     = carry_q;
    divcero_d   = divcero_q;
    nueva       = 1'b0;
    case (estado_q)
      LIBRE:     nueva = acepta;
      CALCULO: begin
        if (hecho) begin
          estado_d    = RESULTADO;
          resultado_d = res_iter;
          neg_d       = res_iter[N-1];
          cero_d      = (res_iter == '0);
          ovf_d       = 1'b0;
          carry_d     = alto_no_cero;
          divcero_d   = div_cero;
        end
      end
      RESULTADO: begin
        if (salida_lista) begin
          estado_d = LIBRE;
          nueva    = acepta;
        end
      end
      default:   estado_d = LIBRE;
    endcase
    if (nueva) begin
      if (iter_op) begin
        estado_d = CALCULO;
      end else begin
        estado_d    = RESULTADO;
        resultado_d = legado.res[N-1:0];
        neg_d       = legado.res[N-1];
        cero_d      = (legado.res[N-1:0] == '0);
        ovf_d       = legado.ovf;
        carry_d     = legado.carry;
        divcero_d   = 1'b0;
      end
    end
    valida_d = (estado_d == RESULTADO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= LIBRE;
      resultado_q <= '0;
      neg_q       <= 1'b0;
      cero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      carry_q     <= 1'b0;
      divcero_q   <= 1'b0;
      valida_q    <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      resultado_q <= resultado_d;
      neg_q       <= neg_d;
      cero_q      <= cero_d;
      ovf_q       <= ovf_d;
      carry_q     <= carry_d;
      divcero_q   <= divcero_d;
      valida_q    <= valida_d;
    end
  end

  assign salida_valida  = valida_q;
  assign resultadoFinal = resultado_q;
  assign flagNegativo   = neg_q;
  assign flagCero       = cero_q;
  assign flagOverflow   = ovf_q;
  assign flagCarry      = carry_q;
  assign flagDivCero    = divcero_q;

endmodule

// File: tb/tb_unidad_logico_aritmetica_secuencial.sv
// Scoreboard bench for the sequential ALU at N=8: directed stimulus pushes expected results,
// an independent monitor pops and compares on every output handshake.
module tb_unidad_logico_aritmetica_secuencial;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         entrada_valida, entrada_lista;
  logic [N-1:0] operador1, operador2;
  logic [4:0]   ALUControl;
  logic         salida_valida, salida_lista;
  logic [N-1:0] resultadoFinal;
  logic         flagNegativo, flagCero, flagOverflow, flagCarry, flagDivCero;

  always #5 clk = ~clk;

  unidad_logico_aritmetica_secuencial #(.N(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .entrada_valida (entrada_valida),
    .entrada_lista  (entrada_lista),
    .operador1      (operador1),
    .operador2      (operador2),
    .ALUControl     (ALUControl),
    .salida_valida  (salida_valida),
    .salida_lista   (salida_lista),
    .resultadoFinal (resultadoFinal),
    .flagNegativo   (flagNegativo),
    .flagCero       (flagCero),
    .flagOverflow   (flagOverflow),
    .flagCarry      (flagCarry),
    .flagDivCero    (flagDivCero)
  );

  typedef struct {
    string       nombre;
    logic [12:0] valor;
  } entrada_t;

  entrada_t cola[$];
  int       pasadas = 0;
  int       totales = 0;

  // {result, N, Z, V, C, D}
  function automatic logic [12:0] esp(input logic [7:0] r, input logic n, z, v, c, d);
    return {r, n, z, v, c, d};
  endfunction

  function automatic logic [12:0] observado();
    return {resultadoFinal, flagNegativo, flagCero, flagOverflow, flagCarry, flagDivCero};
  endfunction

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
    totales++;
    if (act === req) pasadas++;
    else $display("FAIL %s actual=%0h required=%0h", nombre, act, req);
  endtask

  initial begin : monitor
    entrada_t e;
    forever begin
      @(negedge clk);
      if (rst_n && salida_valida && salida_lista) begin
        if (cola.size() == 0) begin
          totales++;
          $display("FAIL unexpected_result actual=%0h required=none", observado());
        end else begin
          e = cola.pop_front();
          chk(e.nombre, 32'(observado()), 32'(e.valor));
        end
      end
    end
  end

  task automatic emitir(input string nom, input logic [4:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [12:0] valor);
    int t = 0;
    while (!entrada_lista && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!entrada_lista) begin
      totales++;
      $display("FAIL %s_ready_timeout actual=0 required=1", nom);
    end
    entrada_valida = 1'b1;
    ALUControl     = op;
    operador1      = a;
    operador2      = b;
    cola.push_back('{nom, valor});
    @(posedge clk); #1;
    entrada_valida = 1'b0;
    ALUControl     = 5'($urandom);
    operador1      = 8'($urandom);
    operador2      = 8'($urandom);
  endtask

  task automatic emitir_simple(input string nom, input logic [4:0] op, input logic [7:0] a,
                               input logic [7:0] b, input logic [12:0] valor);
    emitir(nom, op, a, b, valor);
    chk({nom, "_latency"}, 32'(salida_valida), 32'd1);
  endtask

  task automatic emitir_iter(input string nom, input logic [4:0] op, input logic [7:0] a,
                             input logic [7:0] b, input logic [12:0] valor);
    int lento = 0;
    emitir(nom, op, a, b, valor);
    for (int i = 0; i < N; i++) begin
      if (entrada_lista || salida_valida) lento++;
      @(posedge clk); #1;
    end
    chk({nom, "_stall"}, 32'(lento), 32'd0);
    chk({nom, "_latency"}, 32'(salida_valida), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin : estimulo
    int t;
    int vistos;
    rst_n          = 1'b0;
    entrada_valida = 1'b0;
    salida_lista   = 1'b1;
    ALUControl     = 5'd0;
    operador1      = '0;
    operador2      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({observado(), salida_valida}), 32'd0);
    chk("reset_ready", 32'(entrada_lista), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    emitir_simple("add_7f_01", 5'd8,  8'h7F, 8'h01, esp(8'h80, 1, 0, 1, 0, 0));
    emitir_simple("sub_05_05", 5'd9,  8'h05, 8'h05, esp(8'h00, 0, 1, 0, 1, 0));
    emitir_simple("ror_81_1",  5'd14, 8'h81, 8'h01, esp(8'hC0, 1, 0, 0, 0, 0));
    emitir_simple("and",       5'd0,  8'hF0, 8'h3C, esp(8'h30, 0, 0, 0, 0, 0));
    emitir_simple("sub_03_05", 5'd9,  8'h03, 8'h05, esp(8'hFE, 1, 0, 0, 0, 0));
    emitir_simple("asr_a",     5'd10, 8'h84, 8'h00, esp(8'hC2, 1, 0, 0, 0, 0));
    emitir_simple("reserved",  5'd19, 8'hFF, 8'hFF, esp(8'h00, 0, 1, 0, 0, 0));

    emitir_iter("mul_15_17", 5'd16, 8'd15,  8'd17, esp(8'hFF, 1, 0, 0, 0, 0));
    emitir_iter("mul_16_16", 5'd16, 8'd16,  8'd16, esp(8'h00, 0, 1, 0, 1, 0));
    emitir_iter("div_200_7", 5'd17, 8'd200, 8'd7,  esp(8'd28, 0, 0, 0, 0, 0));
    emitir_iter("mod_200_7", 5'd18, 8'd200, 8'd7,  esp(8'd4,  0, 0, 0, 0, 0));
    emitir_iter("div_9_0",   5'd17, 8'd9,   8'd0,  esp(8'hFF, 1, 0, 0, 0, 1));
    emitir_iter("mod_9_0",   5'd18, 8'd9,   8'd0,  esp(8'd9,  0, 0, 0, 0, 1));

    // backpressure followed by a back-to-back XOR on the release edge
    @(posedge clk); #1;
    salida_lista = 1'b0;
    emitir("add_hold", 5'd8, 8'hF0, 8'h20, esp(8'h10, 0, 0, 0, 1, 0));
    for (int i = 0; i < 5; i++) begin
      chk("hold_data", 32'(observado()), 32'(esp(8'h10, 0, 0, 0, 1, 0)));
      chk("hold_handshake", 32'({salida_valida, entrada_lista}), 32'b10);
      @(posedge clk); #1;
    end
    salida_lista = 1'b1;
    emitir("xor_b2b", 5'd2, 8'hA5, 8'hFF, esp(8'h5A, 0, 0, 0, 0, 0));
    chk("b2b_valid_held", 32'({salida_valida, resultadoFinal}), 32'h15A);

    // reset four cycles into a multiply
    @(posedge clk); #1;
    emitir("mul_abort", 5'd16, 8'd11, 8'd13, esp(8'd143, 1, 0, 0, 0, 0));
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 32'({observado(), salida_valida}), 32'd0);
    cola.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_ready", 32'(entrada_lista), 32'd1);
    vistos = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (salida_valida) vistos++;
    end
    chk("abort_no_partial", 32'(vistos), 32'd0);
    emitir_simple("add_3_4", 5'd8, 8'd3, 8'd4, esp(8'd7, 0, 0, 0, 0, 0));

    t = 0;
    while (cola.size() != 0 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk("queue_drained", 32'(cola.size()), 32'd0);
    $display("%0d/%0d checks passed", pasadas, totales);
    $finish;
  end

endmodule

// File: doc/unidad_logico_aritmetica_secuencial.md
# unidad_logico_aritmetica_secuencial

Parametrised, registered successor to the datapath ALU. It keeps the 16 single-cycle logic, shift and add operations and adds iterative unsigned multiply, divide and remainder. All results and flags are registered behind a valid/ready handshake. It sits between the decode stage (producer) and the register-writeback stage (consumer). Multi-cycle operations stall the producer through `entrada_lista`.

## Interface
- `N`, default 32: operand and result width; power of two, minimum 4.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `entrada_valida` input 1: producer presents an operation.
- `entrada_lista` output 1: block can accept an operation this cycle.
- `operador1`, `operador2` input N: operands A and B.
- `ALUControl` input 5: opcode.
- `salida_valida` output 1: result and flags valid.
- `salida_lista` input 1: consumer accepts the result.
- `resultadoFinal` output N: registered result.
- `flagNegativo`, `flagCero`, `flagOverflow`, `flagCarry`, `flagDivCero` output 1 each: registered flags.

## Operation
- Accept occurs when `entrada_valida && entrada_lista`. Operands and opcode are captured on that edge.
- Opcodes `0xxxx`, single-cycle:
  - 0 AND, 1 OR, 2 XOR, 3 NOT A.
  - 4 LSR A by 1, 5 LSL A by 1, 6 LSR B by 1, 7 LSL B by 1.
  - 8 ADD A+B, 9 SUB A−B.
  - 10 ASR A by 1, 11 ASL A by 1, 12 ASR B by 1, 13 ASL B by 1.
  - 14 rotate A right by B[$clog2(N)-1:0].
  - 15 result 0.
- Opcodes `10000` MUL (low N bits of A×B), `10001` DIV (A/B), `10010` MOD (A%B). All are unsigned and iterative.
- Opcodes `10011`–`11111` are reserved: result 0, single-cycle, no error.
- FSM:
  - LIBRE: on accept, go to CALCULO for MUL/DIV/MOD, otherwise to RESULTADO.
  - CALCULO: runs exactly N iterations, then goes to RESULTADO. MUL is shift-add over a 2N-bit product. DIV/MOD is a restoring divider.
  - RESULTADO: holds outputs.
    - If `salida_lista` and no accept, go to LIBRE.
    - If `salida_lista` and an accept occurs in the same cycle, go to CALCULO or RESULTADO per the new opcode (back-to-back).
- `entrada_lista = (estado==LIBRE) || (estado==RESULTADO && salida_lista)`.
- Flags:
  - `flagNegativo` = result[N-1] and `flagCero` = (result==0), for every opcode.
  - ADD: `flagCarry` = carry out; `flagOverflow` = signed overflow.
  - SUB: `flagCarry` = no borrow (A ≥ B unsigned); `flagOverflow` = signed overflow.
  - MUL: `flagCarry` = upper N bits of the product are nonzero; `flagOverflow` = 0.
  - All other opcodes: C = V = 0.
  - `flagDivCero` = 1 only for DIV/MOD with B==0; otherwise 0.
- Divide by zero:
  - DIV returns all ones and MOD returns A.
  - The full N-cycle latency is kept, so timing does not depend on operand values.

## Timing
- Reset, or any cycle with `rst_n` low: state LIBRE, `salida_valida`=0, `resultadoFinal`=0, all flags 0, iteration counter 0. No accept can occur while `rst_n` is low.
- Single-cycle op accepted at edge k: `salida_valida`=1 from edge k+1.
- MUL/DIV/MOD accepted at edge k: `salida_valida`=1 from edge k+N+1. `entrada_lista`=0 for cycles k+1 through k+N.
- Once `salida_valida` rises, it and all data and flags stay stable until the edge where `salida_lista`=1.
- After that edge, `salida_valida` drops unless a back-to-back single-cycle op was accepted on the same edge; in that case the new result appears with `salida_valida` held at 1.
- Reset asserted mid-CALCULO aborts the operation immediately (asynchronously). No partial result is ever presented.
- Inputs are ignored when no accept occurs. Operand changes during CALCULO have no effect.

## Structure
- `alu_secuencial_pkg`:
  - typedef `op_alu_t`: enum of the 5-bit opcodes.
  - typedef `estado_alu_t`: LIBRE, CALCULO, RESULTADO.
  - Functions for the legacy single-cycle result and flags.
- Sub-module `multiplicador_divisor_iterativo #(N)`:
  - Inputs: start, mode (MUL/DIV/MOD), A, B.
  - Outputs: done pulse, result, upper-half-nonzero, divide-by-zero.
  - Owns the iteration counter and the 2N-bit working register.
- The top level owns the FSM, the handshake, the single-cycle datapath and the output registers.

## Test plan
All scenarios use N=8.
- ADD 8'h7F + 8'h01, `salida_lista`=1 → 8'h80, N=1, Z=0, V=1, C=0, `salida_valida` one cycle after accept.
- SUB 8'h05 − 8'h05 → 8'h00, Z=1, C=1, V=0. Rotate 8'h81 by 1 → 8'hC0.
- MUL 15×17 → 8'hFF with C=0. MUL 16×16 → 8'h00 with Z=1, C=1. Both have `salida_valida` 9 cycles after accept and `entrada_lista`=0 for 8 cycles.
- DIV 200/7 → 28. MOD 200/7 → 4. DIV 9/0 → 8'hFF with `flagDivCero`=1. MOD 9/0 → 9.
- Backpressure and back-to-back:
  - Hold `salida_lista`=0 for 5 cycles after an ADD result: result and flags stay stable, `entrada_lista`=0.
  - Then raise `salida_lista` with a new XOR offered: XOR is accepted on the same edge and its result appears next cycle with `salida_valida` continuously 1.
- Reset during CALCULO, 4 cycles into a MUL: all outputs read 0 and `entrada_lista`=1 after release. A following ADD 3+4 returns 7 with correct flags.
